// File: rtl/comm_pkg.sv
// Shared constants and helpers for the interleaver/deinterleaver pair.
// The defaults match the constants used by the transmit-side interleaver.
package comm_pkg;

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;

    function automatic int block_bits(input int rows, input int cols);
        return rows * cols;
    endfunction

    // Width of an index that counts 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/deint_addr_gen.sv
// Column-major address generator: walks k = r*COLS + c and presents c*ROWS + r.
// The address is kept as a running register, so no multiplier is needed.
module deint_addr_gen
    import comm_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    localparam int AW  = idx_width(block_bits(ROWS, COLS))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    output logic [AW-1:0] addr,
    output logic          first,
    output logic          last
);

    localparam int RW = idx_width(ROWS);
    localparam int CW = idx_width(COLS);

    logic [RW-1:0] r;
    logic [CW-1:0] c;

    // Stepping c adds ROWS to the address; wrapping c restarts at the next row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r    <= '0;
            c    <= '0;
            addr <= '0;
        end else if (advance) begin
            if (c == CW'(COLS - 1)) begin
                c <= '0;
                if (r == RW'(ROWS - 1)) begin
                    r    <= '0;
                    addr <= '0;
                end else begin
                    r    <= r + RW'(1);
                    addr <= AW'(r) + AW'(1);
                end
            end else begin
                c    <= c + CW'(1);
                addr <= addr + AW'(ROWS);
            end
        end
    end

    assign first = (r == '0) && (c == '0);
    assign last  = (r == RW'(ROWS - 1)) && (c == CW'(COLS - 1));

endmodule

// File: rtl/block_deinterleaver.sv
// Bit-serial ROWS x COLS ping-pong block deinterleaver with start-of-block resync.
// Define BLOCK_DEINT_SYNC_CNT_EN to add the saturating sync_err_cnt output.
module block_deinterleaver
    import comm_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_sof,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_sof
`ifdef BLOCK_DEINT_SYNC_CNT_EN
    ,
    output logic [7:0] sync_err_cnt
`endif
);

    localparam int N  = block_bits(ROWS, COLS);
    localparam int AW = idx_width(N);

    logic [N-1:0]  bank [2];
    logic [1:0]    full;
    logic          wr_sel;
    logic          rd_sel;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          rd_first;
    logic          rd_last;
    logic          in_fire;
    logic          out_fire;
    logic          resync;

    assign in_ready  = !full[wr_sel];
    assign in_fire   = in_valid && in_ready;
    assign out_valid = full[rd_sel];
    assign out_fire  = out_valid && out_ready;
    assign resync    = in_fire && in_sof && (wr_idx != '0);
    assign wr_addr   = resync ? '0 : wr_idx;
    assign out_bit   = out_valid && bank[rd_sel][rd_addr];
    assign out_sof   = out_valid && rd_first;

    // Fill and drain always target different banks, so both full bits may change together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            wr_idx <= '0;
        end else begin
            if (in_fire) begin
                if (resync) begin
                    wr_idx <= AW'(1);
                end else if (wr_idx == AW'(N - 1)) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= !wr_sel;
                    wr_idx       <= '0;
                end else begin
                    wr_idx <= wr_idx + AW'(1);
                end
            end
            if (out_fire && rd_last) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= !rd_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            bank[wr_sel][wr_addr] <= in_bit;
        end
    end

    deint_addr_gen #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_rd_addr (
        .clk     (clk),
        .rst     (rst),
        .advance (out_fire),
        .addr    (rd_addr),
        .first   (rd_first),
        .last    (rd_last)
    );

`ifdef BLOCK_DEINT_SYNC_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_err_cnt <= '0;
        end else if (resync && (sync_err_cnt != 8'hFF)) begin
            sync_err_cnt <= sync_err_cnt + 8'd1;
        end
    end
`else
    // Without the counter a resync still realigns the write pointer silently.
`endif

endmodule

// File: doc/block_deinterleaver.md
Name: block_deinterleaver

Overview:
- Bit-serial ROWS x COLS block deinterleaver. It sits directly downstream of the channel/demodulator path and undoes the transmit-side block interleaver: the transmitter writes row-major and reads column-major.
- Ping-pong storage: one bank fills while the other drains, so sustained throughput is 1 bit/cycle.
- Frame alignment comes from an explicit start-of-block marker. Valid/ready handshakes on both sides.

Parameters:
- ROWS, 4, interleaver row count (>=2)
- COLS, 4, interleaver column count (>=2)
- N (derived localparam, not overridable), ROWS*COLS, bits per block

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_bit/in_sof valid
- in_ready  out  1  block can accept a bit this cycle
- in_bit  in  1  received (interleaved) bit
- in_sof  in  1  first bit of a block
- out_valid  out  1  out_bit valid
- out_ready  in  1  downstream accepts
- out_bit  out  1  deinterleaved bit
- out_sof  out  1  first bit of output block
- sync_err_cnt  out  8  only when BLOCK_DEINT_SYNC_CNT_EN defined

Behaviour:
- Transfers: input on in_valid & in_ready; output on out_valid & out_ready.
- Storage: bank[0], bank[1], N bits each. Per-bank full flag full[b]. Write pointer wr_sel/wr_idx (0..N-1). Read pointer rd_sel/rd_idx.
- Write addressing:
  - Incoming bit j (j = arrival order in block) is stored at bank[wr_sel][j].
  - When j == N-1 is accepted: full[wr_sel] <= 1, wr_sel toggles, wr_idx <= 0.
- in_ready = !full[wr_sel].
- Read addressing:
  - Output k = r*COLS + c, with r = k / COLS and c = k % COLS.
  - out_bit = bank[rd_sel][c*ROWS + r].
  - Implement with r/c counters (c wraps at COLS, then r increments), not divide/modulo.
- Read control:
  - out_valid = full[rd_sel].
  - out_sof = out_valid & (rd_idx == 0).
  - Output is combinational from registered state (registered address, RAM/array read).
  - On accepting k == N-1: full[rd_sel] <= 0, rd_sel toggles, counters reset.
  - No gaps inside a block while out_ready is high.
- Latency: first out_valid in the cycle after the N-th input bit of a block is accepted.
- Simultaneous events:
  - A write completing bank A and a read freeing bank B in the same cycle are both applied.
  - A read freeing bank B in the same cycle in_ready is low for B: in_ready rises the next cycle (no combinational ready path).
- Sync rules:
  - in_sof accepted with wr_idx != 0: partial block discarded, bit written at index 0, wr_idx <= 1. Sync error event.
  - in_sof is not required on aligned blocks. Bits arriving after reset with no prior in_sof are written from index 0.
- Backpressure: out_ready low holds out_bit/out_sof/out_valid stable. Both banks full -> in_ready = 0.
- Reset (async, any time, including mid-block):
  - full = 0, wr_sel = rd_sel = 0, all indices 0.
  - out_valid = 0, out_bit = 0, out_sof = 0, in_ready = 1.
  - Bank contents need not be cleared.

Optional Feature:
- Macro BLOCK_DEINT_SYNC_CNT_EN.
- Defined: sync_err_cnt port present. Increments by 1 on each sync error event, saturates at 255, reset to 0.
- Undefined: port and counter absent; resync behaviour unchanged.

Decomposition:
- Shared package comm_pkg: N computation helper, index width function clog2(N), and shared ROWS/COLS defaults.
- These defaults are the same constants the transmit-side interleaver uses.
- One natural sub-module: deint_addr_gen (r/c counters producing c*ROWS+r, with wrap/last flags). Reusable for the transmit-side read order.

Test Plan:
- 4x4, bits 0..15 written row-major into an interleaver model and sent column-major with in_sof on the first bit -> output in_bits 0..15 restored in order; out_sof on the first; first out_valid 1 cycle after the 16th input.
- Continuous 3 blocks with out_ready=1 -> in_ready never drops; output stream gap-free, 48 bits correct.
- out_ready=0 for 40 cycles while sending -> in_ready drops after exactly 32 accepted bits; releasing out_ready restores data with no loss or duplication.
- in_sof at wr_idx=7 -> first 7 bits dropped; next output block comes from the new frame; sync_err_cnt=1 (when enabled); 300 such events -> counter stays at 255.
- ROWS=3, COLS=5 -> non-square permutation verified against reference model for 4 random blocks.
- rst pulsed mid-readout at k=9 -> out_valid=0 immediately (async); after release, a fresh block is deinterleaved correctly from index 0.
